// File: rtl/mx_block_serializer.sv
// rtl/mx_block_serializer.sv - holds one MX block and streams it out lanes elements per beat
module mx_block_serializer #(
  parameter int exp_width = 3,
  parameter int man_width = 2,
  parameter int bit_width = 1 + exp_width + man_width,
  parameter int k         = 32,
  parameter int lanes     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [bit_width-1:0]       i_mx_vec [k],
  input  logic [7:0]                 i_mx_exp,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [lanes*bit_width-1:0] o_data,
  output logic [7:0]                 o_scale,
  output logic                       o_first,
  output logic                       o_last,
  output logic                       o_valid,
  input  logic                       i_ready
);

  localparam int beats      = k / lanes;
  localparam int beat_w     = (beats > 1) ? $clog2(beats) : 1;
  localparam int beat_bits  = lanes * bit_width;
  localparam int block_bits = k * bit_width;
  localparam logic [beat_w-1:0] last_beat = beat_w'(beats - 1);

  if ((k % lanes) != 0) begin : g_bad_cfg
    $error("mx_block_serializer: k must be a multiple of lanes");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [block_bits-1:0] block_q;
  logic [7:0]            exp_q;
  logic [beat_w-1:0]     beat_q;
  logic                  accept;
  logic                  beat_done;

  assign accept    = i_valid && o_ready;
  assign beat_done = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A last-beat handshake that coincides with an accept keeps us in SEND (no bubble).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (beat_done && o_last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_valid = (state_q == SEND) && !i_rst;
    o_first = o_valid && (beat_q == '0);
    o_last  = o_valid && (beat_q == last_beat);
    o_ready = !i_rst && ((state_q == IDLE) || (o_last && i_ready));
    o_scale = o_valid ? exp_q : 8'h00;
    o_data  = '0;
    if (o_valid) begin
      for (int b = 0; b < beats; b++) begin
        if (beat_q == beat_w'(b)) o_data = block_q[b*beat_bits +: beat_bits];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      block_q <= '0;
      exp_q   <= '0;
      beat_q  <= '0;
    end else if (accept) begin
      for (int j = 0; j < k; j++) begin
        block_q[j*bit_width +: bit_width] <= i_mx_vec[j];
      end
      exp_q  <= i_mx_exp;
      beat_q <= '0;
    end else if (beat_done && !o_last) begin
      beat_q <= beat_q + beat_w'(1);
    end
  end

endmodule

// File: tb/tb_mx_block_serializer.sv
// tb/tb_mx_block_serializer.sv - scoreboard bench for mx_block_serializer (lanes=8 and lanes=32)
module tb_mx_block_serializer;

  localparam int kk = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_rst, i_valid, i_ready, o_ready, o_first, o_last, o_valid;
  logic [5:0]  mx_vec [kk];
  logic [7:0]  mx_exp, o_scale;
  logic [47:0] o_data;

  logic         i_valid1, i_ready1, o_ready1, o_first1, o_last1, o_valid1;
  logic [5:0]   mx_vec1 [kk];
  logic [7:0]   mx_exp1, o_scale1;
  logic [191:0] o_data1;

  mx_block_serializer u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_mx_vec(mx_vec), .i_mx_exp(mx_exp), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_scale(o_scale), .o_first(o_first),
    .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready)
  );

  mx_block_serializer #(.k(32), .lanes(32)) u_dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_mx_vec(mx_vec1), .i_mx_exp(mx_exp1), .i_valid(i_valid1),
    .o_ready(o_ready1), .o_data(o_data1), .o_scale(o_scale1), .o_first(o_first1),
    .o_last(o_last1), .o_valid(o_valid1), .i_ready(i_ready1)
  );

  typedef struct {
    logic [191:0] data;
    logic [7:0]   scale;
    logic         first;
    logic         last;
  } beat_t;

  beat_t      q0[$];
  beat_t      q1[$];
  int         hs0[$];
  int         hs1[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         stall_checks = 0;
  logic [5:0] blk [kk];
  logic       rdy_en = 1'b0;
  int         rdy_idx = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int base);
    for (int n = 0; n < kk; n++) blk[n] = 6'((base + n) % 64);
  endtask

  task automatic push_exp0(input logic [7:0] e);
    for (int b = 0; b < 4; b++) begin
      beat_t t;
      t.data = '0;
      for (int j = 0; j < 8; j++) t.data[j*6 +: 6] = blk[b*8 + j];
      t.scale = e;
      t.first = (b == 0);
      t.last  = (b == 3);
      q0.push_back(t);
    end
  endtask

  task automatic push_exp1(input logic [7:0] e);
    beat_t t;
    t.data = '0;
    for (int j = 0; j < kk; j++) t.data[j*6 +: 6] = blk[j];
    t.scale = e;
    t.first = 1'b1;
    t.last  = 1'b1;
    q1.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds i_valid high until the DUT takes the block; returns the cycle stamp of the accepting edge.
  task automatic accept_block(input logic [7:0] e, output int acc_cyc);
    logic acc;
    mx_vec  = blk;
    mx_exp  = e;
    i_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = o_ready;
      tick();
    end
    acc_cyc = cyc;
    check("accept_seen", acc, 1);
  endtask

  task automatic drain0();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (q0.size() == 0) break;
    end
    check("drain_empty", q0.size(), 0);
    tick();
    @(negedge clk);
    check("idle_after_block", o_valid, 0);
    tick();
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rdy_en) begin
        i_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
        rdy_idx++;
      end
    end
  end

  initial begin : mon0
    beat_t       t;
    logic        stall_prev;
    logic [47:0] pd;
    logic [7:0]  ps;
    logic        pf, pl;
    stall_prev = 1'b0;
    pd = '0; ps = '0; pf = 1'b0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        stall_checks++;
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, pd);
        check("stall_scale", o_scale, ps);
        check("stall_first", o_first, pf);
        check("stall_last", o_last, pl);
      end
      if (o_valid && i_ready) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat0: got beat %0h expected none", o_data);
        end else begin
          t = q0.pop_front();
          check("beat0_data", o_data, t.data);
          check("beat0_scale", o_scale, t.scale);
          check("beat0_first", o_first, t.first);
          check("beat0_last", o_last, t.last);
          hs0.push_back(cyc);
        end
      end
      stall_prev = o_valid && !i_ready;
      pd = o_data; ps = o_scale; pf = o_first; pl = o_last;
    end
  end

  initial begin : mon1
    beat_t t;
    forever begin
      @(negedge clk);
      if (o_valid1 && i_ready1) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat1: got beat %0h expected none", o_data1);
        end else begin
          t = q1.pop_front();
          check("beat1_data", o_data1, t.data);
          check("beat1_scale", o_scale1, t.scale);
          check("beat1_first", o_first1, t.first);
          check("beat1_last", o_last1, t.last);
          hs1.push_back(cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a0, a1, n0, n1;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; mx_exp = 8'h00;
    i_valid1 = 1'b0; i_ready1 = 1'b1; mx_exp1 = 8'h00;
    fill(0);
    mx_vec = blk;
    mx_vec1 = blk;
    repeat (2) tick();

    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_first", o_first, 0);
    check("rst_last", o_last, 0);
    check("rst_data", o_data, 0);
    check("rst_scale", o_scale, 0);
    check("rst_valid1", o_valid1, 0);
    tick();
    i_rst = 1'b0;
    @(negedge clk);
    check("idle_ready", o_ready, 1);
    check("idle_valid", o_valid, 0);
    tick();

    // single block, elements 0..31, exp 0x7F
    fill(0);
    push_exp0(8'h7F);
    n0 = hs0.size();
    accept_block(8'h7F, a0);
    i_valid = 1'b0;
    @(negedge clk);
    check("t1_latency_valid", o_valid, 1);
    check("t1_latency_first", o_first, 1);
    check("t1_b0_lane0", o_data[5:0], 6'd0);
    repeat (3) tick();
    @(negedge clk);
    check("t1_b3_lane7", o_data[47:42], 6'd31);
    check("t1_b3_last", o_last, 1);
    drain0();
    check("t1_beat_count", hs0.size() - n0, 4);
    if (hs0.size() >= n0 + 4) check("t1_consecutive", hs0[n0+3] - hs0[n0], 3);

    // back-to-back blocks
    fill(5);
    push_exp0(8'h10);
    n0 = hs0.size();
    accept_block(8'h10, a0);
    fill(40);
    push_exp0(8'h20);
    accept_block(8'h20, a1);
    i_valid = 1'b0;
    check("t2_accept_gap", a1 - a0, 4);
    drain0();
    check("t2_beat_count", hs0.size() - n0, 8);
    if (hs0.size() >= n0 + 8) check("t2_no_bubble", hs0[n0+7] - hs0[n0], 7);

    // downstream stalls 1,0,0,1
    rdy_idx = 0;
    rdy_en = 1'b1;
    fill(17);
    push_exp0(8'h55);
    n0 = hs0.size();
    accept_block(8'h55, a0);
    i_valid = 1'b0;
    drain0();
    rdy_en = 1'b0;
    i_ready = 1'b1;
    check("t3_beat_count", hs0.size() - n0, 4);
    check("t3_stalls_seen", stall_checks > 0, 1);
    tick();

    // new block offered mid-send must wait for the last-beat handshake
    fill(9);
    push_exp0(8'h33);
    accept_block(8'h33, a0);
    fill(50);
    push_exp0(8'h44);
    mx_vec = blk;
    mx_exp = 8'h44;
    i_valid = 1'b1;
    @(negedge clk);
    check("t4_ready_b0", o_ready, 0);
    tick();
    @(negedge clk);
    check("t4_valid_b1", o_valid, 1);
    check("t4_first_b1", o_first, 0);
    check("t4_ready_b1", o_ready, 0);
    tick();
    accept_block(8'h44, a1);
    i_valid = 1'b0;
    check("t4_accept_gap", a1 - a0, 4);
    drain0();

    // reset pulse after beat 1 handshake
    fill(20);
    push_exp0(8'h66);
    accept_block(8'h66, a0);
    i_valid = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    if (q0.size() >= 2) begin
      void'(q0.pop_back());
      void'(q0.pop_back());
    end
    @(negedge clk);
    check("t5_rst_valid", o_valid, 0);
    check("t5_rst_ready", o_ready, 0);
    tick();
    i_rst = 1'b0;
    @(negedge clk);
    check("t5_post_valid", o_valid, 0);
    check("t5_post_ready", o_ready, 1);
    check("t5_beats_before_rst", q0.size(), 0);
    tick();
    fill(33);
    push_exp0(8'h77);
    n0 = hs0.size();
    accept_block(8'h77, a0);
    i_valid = 1'b0;
    drain0();
    check("t5_next_block_beats", hs0.size() - n0, 4);

    // lanes=32: one beat per block, a new block every cycle
    n1 = hs1.size();
    for (int n = 0; n < 3; n++) begin
      fill(n * 11);
      push_exp1(8'(8'h40 + n));
      mx_vec1 = blk;
      mx_exp1 = 8'(8'h40 + n);
      i_valid1 = 1'b1;
      @(negedge clk);
      check("t6_ready1", o_ready1, 1);
      tick();
    end
    i_valid1 = 1'b0;
    repeat (3) tick();
    check("t6_drain1", q1.size(), 0);
    check("t6_beat_count", hs1.size() - n1, 3);
    if (hs1.size() >= n1 + 3) check("t6_every_cycle", hs1[n1+2] - hs1[n1], 2);
    check("end_q0_empty", q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mx_block_serializer.md
MX_BLOCK_SERIALIZER -- requirements
Module: mx_block_serializer

Interface
REQ-001 SHALL have parameter exp_width, default 3, meaning element exponent bits.
REQ-002 SHALL have parameter man_width, default 2, meaning element mantissa bits.
REQ-003 SHALL have parameter bit_width, default 1+exp_width+man_width, meaning element width.
REQ-004 SHALL have parameter k, default 32, meaning elements per MX block.
REQ-005 SHALL have parameter lanes, default 8, meaning elements per output beat; k mod lanes != 0 SHALL be an elaboration error.
REQ-006 SHALL have port i_clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port i_mx_vec, input, k x bit_width (unpacked [k]), meaning block elements from the bf16-to-MXFP converter.
REQ-009 SHALL have port i_mx_exp, input, 8, meaning the block shared exponent.
REQ-010 SHALL have port i_valid, input, 1, meaning the input block is valid.
REQ-011 SHALL have port o_ready, output, 1, meaning a block is accepted this cycle when i_valid and o_ready are both high.
REQ-012 SHALL have port o_data, output, lanes*bit_width, meaning packed elements of the current beat.
REQ-013 SHALL have port o_scale, output, 8, meaning the shared exponent of the block being sent.
REQ-014 SHALL have port o_first, output, 1, meaning the current beat is beat 0 of a block.
REQ-015 SHALL have port o_last, output, 1, meaning the current beat is beat k/lanes-1.
REQ-016 SHALL have port o_valid, output, 1, meaning the output beat is valid.
REQ-017 SHALL have port i_ready, input, 1, meaning the downstream consumer accepts the beat when o_valid and i_ready are both high.

Function
REQ-018 SHALL implement states IDLE (no block held) and SEND (block held, beats outstanding).
REQ-019 SHALL assert o_ready in IDLE, and in SEND only when o_last, o_valid and i_ready are all high (back-to-back blocks); o_ready SHALL be 0 otherwise.
REQ-020 On acceptance, SHALL register the full block and exponent, set beat counter to 0, enter SEND; o_valid SHALL rise the following cycle (latency 1 cycle from accept to first beat).
REQ-021 Beat b SHALL carry element b*lanes+j in o_data[j*bit_width +: bit_width], j=0..lanes-1.
REQ-022 o_first SHALL be 1 exactly when beat counter = 0; o_last exactly when beat counter = k/lanes-1; both high together when k = lanes.
REQ-023 o_scale SHALL equal the registered exponent on every beat of the block.
REQ-024 While o_valid=1 and i_ready=0, o_data, o_scale, o_first and o_last SHALL hold stable.
REQ-025 On o_valid and i_ready with beat counter < k/lanes-1, counter SHALL increment by 1.
REQ-026 On the last beat handshake with no new block accepted, SHALL return to IDLE, o_valid=0 next cycle.
REQ-027 On the last beat handshake with a simultaneous input accept, SHALL stay in SEND, load the new block, counter = 0, o_valid stays 1 (no bubble).
REQ-028 o_valid SHALL never depend combinationally on i_ready; o_ready MAY depend combinationally on i_ready.
REQ-029 i_valid with o_ready=0 SHALL be ignored; the input block is not captured.

Reset
REQ-030 While i_rst=1: o_valid=0, o_ready=0, o_first=0, o_last=0, o_data=0, o_scale=0, state IDLE, counter 0.
REQ-031 Reset asserted mid-block SHALL discard the held block and remaining beats; o_ready=1 in the first cycle after i_rst falls.

Verification
REQ-032 Defaults, i_ready=1, one block elements e[n]=n (mod 64), exp=0x7F -> 4 beats on consecutive cycles starting 1 cycle after accept; beat 0 lane 0 = 0, beat 3 lane 7 = 31; o_scale=0x7F on all; o_first beat 0 only, o_last beat 3 only.
REQ-033 Two blocks exp 0x10 then 0x20, i_valid held, i_ready=1 -> 8 consecutive valid beats, no bubble, o_scale changes 0x10->0x20 at beat 4.
REQ-034 i_ready toggled 1,0,0,1,... during block -> o_data/o_scale/o_first/o_last stable on stalled cycles; 4 beats accepted, none lost or duplicated.
REQ-035 i_valid=1 during SEND with beat counter 1 -> o_ready=0, block not captured; captured only on last-beat handshake.
REQ-036 i_rst pulsed for 1 cycle after beat 1 handshake -> o_valid=0 next cycle, no further beats of that block; next block sends beats 0..3 normally.
REQ-037 Parameter run lanes=32, k=32 -> single beat per block with o_first=o_last=1, back-to-back blocks every cycle under i_ready=1.
